// File: rtl/vec_mem_pkg.sv
// Shared definitions for the wide vector memory and its sweep engine:
// default geometry, sweep state encoding and a lane-slicing helper.
package vec_mem_pkg;

    localparam int NO_OF_UNITS_DEF   = 8;
    localparam int ELEMENT_WIDTH_DEF = 32;
    localparam int DEPTH_DEF         = 1024;
    localparam int ADDR_WIDTH_DEF    = 10;
    localparam int WORD_WIDTH_DEF    = NO_OF_UNITS_DEF * ELEMENT_WIDTH_DEF;

    typedef enum logic [1:0] {
        SWEEP_IDLE,
        SWEEP_FETCH,
        SWEEP_HOLD,
        SWEEP_DONE
    } sweep_state_e;

    // Bit offset of a lane inside a packed word (lane k sits at k*EW).
    function automatic int lane_lsb(input int lane, input int element_width);
        return lane * element_width;
    endfunction

endpackage

// File: rtl/vector_mem_sweep_fsm.sv
// Sweep sequencer: walks base..base+len-1 (modulo DEPTH), one fetch per beat,
// holding each beat until the consumer accepts it, then pulses done.
module vector_mem_sweep_fsm
    import vec_mem_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sweep_start,
    input  logic [ADDR_WIDTH-1:0] sweep_base,
    input  logic [ADDR_WIDTH:0]   sweep_len,
    input  logic                  sweep_ready,
    input  logic                  rd_en,
    output logic                  fetch_en,
    output logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  start_accept,
    output logic                  sweep_busy,
    output logic                  sweep_valid,
    output logic                  sweep_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE = (ADDR_WIDTH + 1)'(1);

    sweep_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic                  busy_q, valid_q, done_q;

    // Next-state logic; the external read port wins, so FETCH waits while rd_en is high
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        count_d      = count_q;
        len_d        = len_q;
        start_accept = 1'b0;
        fetch_en     = 1'b0;
        case (state_q)
            SWEEP_IDLE: begin
                if (sweep_start) begin
                    start_accept = 1'b1;
                    addr_d       = sweep_base;
                    len_d        = sweep_len;
                    count_d      = '0;
                    state_d      = (sweep_len != '0) ? SWEEP_FETCH : SWEEP_DONE;
                end
            end
            SWEEP_FETCH: begin
                if (!rd_en) begin
                    fetch_en = 1'b1;
                    state_d  = SWEEP_HOLD;
                end
            end
            SWEEP_HOLD: begin
                if (valid_q && sweep_ready) begin
                    count_d = count_q + COUNT_ONE;
                    addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_ONE;
                    state_d = (count_d == len_q) ? SWEEP_DONE : SWEEP_FETCH;
                end
            end
            SWEEP_DONE: begin
                state_d = SWEEP_IDLE;
            end
            default: begin
                state_d = SWEEP_IDLE;
            end
        endcase
    end

    // State, counters and registered status outputs derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SWEEP_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            len_q   <= len_d;
            busy_q  <= (state_d != SWEEP_IDLE);
            valid_q <= (state_d == SWEEP_HOLD);
            done_q  <= (state_d == SWEEP_DONE);
        end
    end

    assign fetch_addr  = addr_q;
    assign sweep_busy  = busy_q;
    assign sweep_valid = valid_q;
    assign sweep_done  = done_q;

endmodule

// File: rtl/vector_mem_sweep.sv
// Wide lane-masked vector memory with a registered read port and a
// ready/valid sweep engine sharing that single read port.
module vector_mem_sweep
    import vec_mem_pkg::*;
#(
    parameter int NO_OF_UNITS   = NO_OF_UNITS_DEF,
    parameter int ELEMENT_WIDTH = ELEMENT_WIDTH_DEF,
    parameter int DEPTH         = DEPTH_DEF,
    parameter int ADDR_WIDTH    = $clog2(DEPTH)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 wr_en,
    input  logic [ADDR_WIDTH-1:0]                wr_addr,
    input  logic [NO_OF_UNITS-1:0]               wr_lane_mask,
    input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] wr_data,
    input  logic                                 rd_en,
    input  logic [ADDR_WIDTH-1:0]                rd_addr,
    output logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] rd_data,
    output logic                                 rd_valid,
    input  logic                                 sweep_start,
    input  logic [ADDR_WIDTH-1:0]                sweep_base,
    input  logic [ADDR_WIDTH:0]                  sweep_len,
    output logic                                 sweep_busy,
    output logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] sweep_data,
    output logic                                 sweep_valid,
    input  logic                                 sweep_ready,
    output logic                                 sweep_done,
    output logic                                 dirty
);

    localparam int WORD_WIDTH = NO_OF_UNITS * ELEMENT_WIDTH;

    logic [WORD_WIDTH-1:0] mem_array [DEPTH];

    logic                  wr_in_range, rd_in_range, wr_hit;
    logic                  fetch_en, start_accept;
    logic [ADDR_WIDTH-1:0] fetch_addr, port_addr;
    logic [WORD_WIDTH-1:0] port_word;

    logic [WORD_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [WORD_WIDTH-1:0] sweep_data_q, sweep_data_d;
    logic                  dirty_q, dirty_d;

    // Range checks only cost logic when DEPTH is not a full power of two
    if (DEPTH >= (1 << ADDR_WIDTH)) begin : g_full_range
        assign wr_in_range = 1'b1;
        assign rd_in_range = 1'b1;
    end else begin : g_partial_range
        assign wr_in_range = (32'(wr_addr) < DEPTH);
        assign rd_in_range = (32'(rd_addr) < DEPTH);
    end

    assign wr_hit = wr_en && wr_in_range;

    vector_mem_sweep_fsm #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .sweep_start  (sweep_start),
        .sweep_base   (sweep_base),
        .sweep_len    (sweep_len),
        .sweep_ready  (sweep_ready),
        .rd_en        (rd_en),
        .fetch_en     (fetch_en),
        .fetch_addr   (fetch_addr),
        .start_accept (start_accept),
        .sweep_busy   (sweep_busy),
        .sweep_valid  (sweep_valid),
        .sweep_done   (sweep_done)
    );

    // Masked lane writes; the array has no reset so contents survive rst_n
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            for (int k = 0; k < NO_OF_UNITS; k++) begin
                if (wr_lane_mask[k]) begin
                    mem_array[wr_addr][lane_lsb(k, ELEMENT_WIDTH) +: ELEMENT_WIDTH] <=
                        wr_data[lane_lsb(k, ELEMENT_WIDTH) +: ELEMENT_WIDTH];
                end
            end
        end
    end

    // Shared read port: external reads preempt the sweep; capture is read-first vs writes
    always_comb begin
        port_addr    = rd_en ? rd_addr : fetch_addr;
        port_word    = mem_array[port_addr];
        rd_data_d    = rd_data_q;
        rd_valid_d   = rd_en;
        sweep_data_d = sweep_data_q;
        dirty_d      = dirty_q;
        if (rd_en) begin
            rd_data_d = rd_in_range ? port_word : '0;
        end
        if (fetch_en) begin
            sweep_data_d = port_word;
        end
        if (start_accept) begin
            dirty_d = 1'b0;
        end
        if (wr_hit) begin
            dirty_d = 1'b1;
        end
    end

    // Output registers and the dirty flag, all cleared by the async reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            sweep_data_q <= '0;
            dirty_q      <= 1'b0;
        end else begin
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            sweep_data_q <= sweep_data_d;
            dirty_q      <= dirty_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign sweep_data = sweep_data_q;
    assign dirty      = dirty_q;

endmodule

// File: tb/tb_vector_mem_sweep.sv
// Self-checking bench for vector_mem_sweep: a word-array reference model plus
// a queue of expected sweep beats, driven by directed and random stimulus.
module tb_vector_mem_sweep;

    localparam int NU    = 8;
    localparam int EW    = 32;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int W     = NU * EW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [NU-1:0] wr_lane_mask = '0;
    logic [W-1:0]  wr_data = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          sweep_start = 1'b0;
    logic [AW-1:0] sweep_base = '0;
    logic [AW:0]   sweep_len = '0;
    logic          sweep_busy;
    logic [W-1:0]  sweep_data;
    logic          sweep_valid;
    logic          sweep_ready = 1'b1;
    logic          sweep_done;
    logic          dirty;

    always #5 clk = ~clk;

    vector_mem_sweep #(
        .NO_OF_UNITS   (NU),
        .ELEMENT_WIDTH (EW),
        .DEPTH         (DEPTH),
        .ADDR_WIDTH    (AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_lane_mask (wr_lane_mask),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .sweep_start  (sweep_start),
        .sweep_base   (sweep_base),
        .sweep_len    (sweep_len),
        .sweep_busy   (sweep_busy),
        .sweep_data   (sweep_data),
        .sweep_valid  (sweep_valid),
        .sweep_ready  (sweep_ready),
        .sweep_done   (sweep_done),
        .dirty        (dirty)
    );

    // Reference state: array contents, expected read port, dirty flag and pending beats
    logic [W-1:0] model [DEPTH];
    logic [W-1:0] exp_rd_data = '0;
    logic         exp_rd_valid = 1'b0;
    logic         exp_dirty = 1'b0;
    logic         expect_done = 1'b0;
    logic [W-1:0] exp_beats [$];
    logic         tb_idle = 1'b1;
    logic         idle_after = 1'b0;
    logic         stall_pending = 1'b0;
    logic [W-1:0] held_data = '0;
    int           beats_seen = 0;
    int           stall_count = 0;
    int           ready_mode = 0;
    logic         ready_phase = 1'b1;
    int           total = 0;
    int           bad = 0;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [W-1:0] randWord();
        logic [W-1:0] w;
        for (int k = 0; k < NU; k++) w[k*EW +: EW] = $urandom;
        return w;
    endfunction

    // One clock: apply the spec rules to the model, advance, then compare outputs
    task automatic tick();
        logic wr_hit;
        expect_done = 1'b0;
        if (ready_mode == 1) begin
            if (sweep_valid) ready_phase = ~ready_phase;
            sweep_ready = ready_phase;
        end else if (ready_mode == 2) begin
            sweep_ready = 1'($urandom_range(0, 1));
        end else begin
            sweep_ready = 1'b1;
        end
        if (stall_pending) begin
            checkOutput("stall_valid", W'(sweep_valid), W'(1));
            checkOutput("stall_data", sweep_data, held_data);
        end
        stall_pending = sweep_valid && !sweep_ready;
        held_data = sweep_data;
        if (stall_pending) stall_count++;
        if (sweep_valid && sweep_ready) begin
            checkOutput("beat_expected", W'(exp_beats.size() != 0), W'(1));
            if (exp_beats.size() != 0) begin
                checkOutput("beat_data", sweep_data, exp_beats.pop_front());
                beats_seen++;
                if (exp_beats.size() == 0) expect_done = 1'b1;
            end
        end
        if (rd_en) exp_rd_data = (int'(rd_addr) < DEPTH) ? model[rd_addr] : '0;
        exp_rd_valid = rd_en;
        wr_hit = wr_en && (int'(wr_addr) < DEPTH);
        if (wr_hit) begin
            for (int k = 0; k < NU; k++)
                if (wr_lane_mask[k]) model[wr_addr][k*EW +: EW] = wr_data[k*EW +: EW];
        end
        if (sweep_start && tb_idle) begin
            exp_dirty = 1'b0;
            tb_idle = 1'b0;
            beats_seen = 0;
            stall_count = 0;
            exp_beats.delete();
            for (int i = 0; i < int'(sweep_len); i++)
                exp_beats.push_back(model[(int'(sweep_base) + i) % DEPTH]);
            if (sweep_len == '0) expect_done = 1'b1;
        end
        if (wr_hit) exp_dirty = 1'b1;
        if (idle_after) begin
            tb_idle = 1'b1;
            idle_after = 1'b0;
        end
        @(posedge clk);
        #1;
        checkOutput("rd_valid", W'(rd_valid), W'(exp_rd_valid));
        checkOutput("rd_data", rd_data, exp_rd_data);
        checkOutput("dirty", W'(dirty), W'(exp_dirty));
        checkOutput("sweep_done", W'(sweep_done), W'(expect_done));
        if (sweep_done) idle_after = 1'b1;
    endtask

    // Drive one cycle of inputs, then drop the strobes again
    task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [NU-1:0] wm,
                                 input logic [W-1:0] wd, input logic re, input logic [AW-1:0] ra,
                                 input logic st, input logic [AW-1:0] sb, input logic [AW:0] sl);
        wr_en = we; wr_addr = wa; wr_lane_mask = wm; wr_data = wd;
        rd_en = re; rd_addr = ra;
        sweep_start = st; sweep_base = sb; sweep_len = sl;
        tick();
        wr_en = 1'b0; rd_en = 1'b0; sweep_start = 1'b0;
    endtask

    task automatic waitSweep(input int budget);
        int n = 0;
        while (!tb_idle && n < budget) begin
            applyStimulus(0, '0, '0, '0, 0, '0, 0, '0, '0);
            n++;
        end
        checkOutput("sweep_finished", W'(tb_idle), W'(1));
    endtask

    task automatic resetModel();
        exp_rd_data = '0; exp_rd_valid = 1'b0; exp_dirty = 1'b0; expect_done = 1'b0;
        exp_beats.delete(); tb_idle = 1'b1; idle_after = 1'b0; stall_pending = 1'b0;
    endtask

    // Hard stop if something hangs
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized sweeps and traffic
    initial begin
        logic [W-1:0] w;
        logic [W-1:0] w5;
        logic [AW-1:0] base;
        logic [AW:0]   len;

        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset_rd_data", rd_data, '0);
        checkOutput("reset_rd_valid", W'(rd_valid), W'(0));
        checkOutput("reset_sweep_data", sweep_data, '0);
        checkOutput("reset_sweep_valid", W'(sweep_valid), W'(0));
        checkOutput("reset_busy", W'(sweep_busy), W'(0));
        checkOutput("reset_done", W'(sweep_done), W'(0));
        checkOutput("reset_dirty", W'(dirty), W'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int a = 0; a < DEPTH; a++)
            applyStimulus(1, AW'(a), '1, randWord(), 0, '0, 0, '0, '0);

        for (int k = 0; k < NU; k++) w5[k*EW +: EW] = 32'(k + 1);
        applyStimulus(1, AW'(5), '1, w5, 0, '0, 0, '0, '0);
        applyStimulus(0, '0, '0, '0, 1, AW'(5), 0, '0, '0);
        checkOutput("rd5_valid", W'(rd_valid), W'(1));
        checkOutput("rd5_lanes", rd_data, w5);
        applyStimulus(0, '0, '0, '0, 0, '0, 0, '0, '0);
        checkOutput("rd_idle_valid", W'(rd_valid), W'(0));
        checkOutput("rd_idle_hold", rd_data, w5);

        w = '0; w[2*EW +: EW] = 32'hDEAD;
        applyStimulus(1, AW'(5), 8'b0000_0100, w, 0, '0, 0, '0, '0);
        applyStimulus(0, '0, '0, '0, 1, AW'(5), 0, '0, '0);
        w = w5; w[2*EW +: EW] = 32'hDEAD;
        checkOutput("mask_lane2", rd_data, w);

        applyStimulus(1, AW'(7), '1, W'(32'hA), 0, '0, 0, '0, '0);
        applyStimulus(1, AW'(7), '1, W'(32'hB), 1, AW'(7), 0, '0, '0);
        checkOutput("read_first_old", rd_data, W'(32'hA));
        applyStimulus(0, '0, '0, '0, 1, AW'(7), 0, '0, '0);
        checkOutput("read_after_new", rd_data, W'(32'hB));

        checkOutput("dirty_before_sweep", W'(dirty), W'(1));
        ready_mode = 1; ready_phase = 1'b1;
        applyStimulus(0, '0, '0, '0, 0, '0, 1, AW'(DEPTH - 2), (AW + 1)'(3));
        checkOutput("wrap_busy", W'(sweep_busy), W'(1));
        waitSweep(100);
        checkOutput("wrap_beats", W'(beats_seen), W'(3));
        checkOutput("wrap_stalls", W'(stall_count), W'(3));
        ready_mode = 0;

        applyStimulus(1, AW'(9), '1, randWord(), 0, '0, 0, '0, '0);
        applyStimulus(0, '0, '0, '0, 0, '0, 1, AW'(20), '0);
        checkOutput("len0_done", W'(sweep_done), W'(1));
        checkOutput("len0_no_valid", W'(sweep_valid), W'(0));
        applyStimulus(0, '0, '0, '0, 0, '0, 0, '0, '0);
        checkOutput("len0_no_valid_after", W'(sweep_valid), W'(0));
        waitSweep(10);

        applyStimulus(0, '0, '0, '0, 0, '0, 1, AW'(100), (AW + 1)'(2));
        for (int i = 0; i < 6; i++) begin
            applyStimulus(i == 1, AW'(300), '1, randWord(), 1, AW'($urandom_range(0, DEPTH - 1)),
                          i == 3, AW'(400), (AW + 1)'(5));
            checkOutput("rdhold_no_valid", W'(sweep_valid), W'(0));
        end
        waitSweep(50);
        checkOutput("rdhold_beats", W'(beats_seen), W'(2));

        for (int s = 0; s < 6; s++) begin
            ready_mode = 2;
            base = (s == 0) ? AW'(DEPTH - 3) : AW'($urandom_range(0, DEPTH - 1));
            len = (AW + 1)'($urandom_range(1, 6));
            applyStimulus(0, '0, '0, '0, 0, '0, 1, base, len);
            for (int n = 0; n < 200 && !tb_idle; n++)
                applyStimulus(0, '0, '0, '0, $urandom_range(0, 3) == 0,
                              AW'($urandom_range(0, DEPTH - 1)), 0, '0, '0);
            checkOutput("rand_sweep_end", W'(tb_idle), W'(1));
            checkOutput("rand_beats", W'(beats_seen), W'(len));
            for (int t = 0; t < 20; t++)
                applyStimulus($urandom_range(0, 1) == 1, AW'($urandom_range(0, DEPTH - 1)),
                              NU'($urandom), randWord(), $urandom_range(0, 1) == 1,
                              AW'($urandom_range(0, DEPTH - 1)), 0, '0, '0);
        end
        ready_mode = 0;

        applyStimulus(0, '0, '0, '0, 0, '0, 1, AW'(50), (AW + 1)'(4));
        for (int n = 0; n < 20 && beats_seen < 1; n++)
            applyStimulus(0, '0, '0, '0, 0, '0, 0, '0, '0);
        checkOutput("midreset_one_beat", W'(beats_seen), W'(1));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", W'(sweep_busy), W'(0));
        checkOutput("midreset_valid", W'(sweep_valid), W'(0));
        checkOutput("midreset_sweep_data", sweep_data, '0);
        checkOutput("midreset_rd_data", rd_data, '0);
        checkOutput("midreset_dirty", W'(dirty), W'(0));
        resetModel();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) applyStimulus(0, '0, '0, '0, 0, '0, 0, '0, '0);
        checkOutput("post_reset_idle", W'(sweep_busy), W'(0));
        for (int a = 50; a < 54; a++) applyStimulus(0, '0, '0, '0, 1, AW'(a), 0, '0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
